usb_fs_in_rr_arb: RTL and testbench

USB_FS_IN_RR_ARB -- requirements
Module: usb_fs_in_rr_arb

---
 rtl/usb_fs_in_rr_arb.sv | 151 +++++++++++++++
 tb/tb_usb_fs_in_rr_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter granting one USB full-speed IN endpoint at a time to the IN protocol engine.
// A grant is locked while the engine is busy and force-released after MAX_HOLD idle cycles.
module usb_fs_in_rr_arb #(
  parameter int NUM_IN_EPS = 4,
  parameter int MAX_HOLD   = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN_EPS-1:0]   in_ep_req,
  output logic [NUM_IN_EPS-1:0]   in_ep_grant,
  input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
  input  logic [NUM_IN_EPS-1:0]   in_ep_data_done,
  input  logic                    pe_busy,
  output logic [7:0]              arb_in_ep_data,
  output logic                    grant_valid,
  output logic [3:0]              grant_idx,
  output logic                    hold_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t                r_state, w_state_n;
  logic [NUM_IN_EPS-1:0] r_grant, w_grant_n, w_onehot;
  logic [3:0]            r_idx, w_idx_n, r_ptr, w_ptr_n, w_ptr_inc, w_pick_idx;
  logic [15:0]           r_cnt, w_cnt_n, w_cnt_inc;
  logic                  r_timeout, w_timeout_n;
  logic                  w_pick_vld, w_req_g, w_done_g, w_hold_lim;
  logic                  w_rel, w_rel_to;
  int                    w_best_d, w_d;

  // Pick the requester with the smallest circular distance from the pointer.
  always_comb begin
    w_pick_idx = '0;
    w_best_d   = NUM_IN_EPS;
    w_d        = 0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (in_ep_req[i]) begin
        w_d = i - int'(r_ptr);
        if (w_d < 0) w_d = w_d + NUM_IN_EPS;
        if (w_d < w_best_d) begin
          w_best_d   = w_d;
          w_pick_idx = 4'(i);
        end
      end
    end
    w_pick_vld = |in_ep_req;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      w_onehot[i] = (4'(i) == w_pick_idx);
    end
  end

  assign w_req_g    = |(in_ep_req & r_grant);
  assign w_done_g   = |(in_ep_data_done & r_grant);
  assign w_ptr_inc  = (r_idx == 4'(NUM_IN_EPS - 1)) ? 4'd0 : r_idx + 4'd1;
  assign w_cnt_inc  = r_cnt + 16'd1;
  assign w_hold_lim = (w_cnt_inc >= 16'(MAX_HOLD));

  always_comb begin
    w_state_n   = r_state;
    w_grant_n   = r_grant;
    w_idx_n     = r_idx;
    w_ptr_n     = r_ptr;
    w_cnt_n     = r_cnt;
    w_timeout_n = 1'b0;
    w_rel       = 1'b0;
    w_rel_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_grant_n = w_onehot;
          w_idx_n   = w_pick_idx;
          w_cnt_n   = '0;
          w_state_n = S_GRANTED;
        end
      end
      S_GRANTED: begin
        // A busy engine takes priority over any release reason in the same cycle.
        if (pe_busy) begin
          w_state_n = S_LOCKED;
          w_cnt_n   = '0;
        end else if (!w_req_g || w_done_g) begin
          w_rel = 1'b1;
        end else if (w_hold_lim) begin
          w_rel    = 1'b1;
          w_rel_to = 1'b1;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      S_LOCKED: begin
        if (!pe_busy) begin
          if (w_req_g && !w_done_g) begin
            w_state_n = S_GRANTED;
            w_cnt_n   = '0;
          end else begin
            w_rel = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_grant_n = '0;
        w_idx_n   = '0;
        w_cnt_n   = '0;
      end
    endcase
    if (w_rel) begin
      w_grant_n   = '0;
      w_idx_n     = '0;
      w_ptr_n     = w_ptr_inc;
      w_cnt_n     = '0;
      w_state_n   = S_IDLE;
      w_timeout_n = w_rel_to;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_grant   <= w_grant_n;
      r_idx     <= w_idx_n;
      r_ptr     <= w_ptr_n;
      r_cnt     <= w_cnt_n;
      r_timeout <= w_timeout_n;
    end
  end

  always_comb begin
    arb_in_ep_data = 8'h00;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      arb_in_ep_data = arb_in_ep_data | (in_ep_data[8*i +: 8] & {8{r_grant[i]}});
    end
  end

  assign in_ep_grant  = r_grant;
  assign grant_valid  = |r_grant;
  assign grant_idx    = grant_valid ? r_idx : 4'd0;
  assign hold_timeout = r_timeout;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Bench for usb_fs_in_rr_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_usb_fs_in_rr_arb;
  localparam int N    = 4;
  localparam int MAXH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req, done, grant;
  logic [N*8-1:0] data;
  logic          busy;
  logic [7:0]    arb_data;
  logic          gvld, to;
  logic [3:0]    gidx;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: owner index (-1 when nobody holds the grant).
  int m_owner, m_ptr, m_held, m_e;
  bit m_locked, m_to, m_found;

  usb_fs_in_rr_arb #(.NUM_IN_EPS(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset_n(reset_n), .in_ep_req(req), .in_ep_grant(grant),
    .in_ep_data(data), .in_ep_data_done(done), .pe_busy(busy),
    .arb_in_ep_data(arb_data), .grant_valid(gvld), .grant_idx(gidx),
    .hold_timeout(to)
  );

  always #5 clk = ~clk;

  task automatic model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_held  = 0;
    m_locked = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_locked = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        m_found = 1'b0;
        for (int k = 0; k < N; k++) begin
          m_e = (m_ptr + k) % N;
          if (!m_found && req[m_e]) begin
            m_found = 1'b1;
            m_owner = m_e;
          end
        end
        m_held = 0;
        m_locked = 1'b0;
      end else if (m_locked) begin
        if (!busy) begin
          if (req[m_owner] && !done[m_owner]) begin
            m_locked = 1'b0;
            m_held = 0;
          end else begin
            model_release();
          end
        end
      end else if (busy) begin
        m_locked = 1'b1;
        m_held = 0;
      end else begin
        m_held++;
        if (!req[m_owner] || done[m_owner]) model_release();
        else if (m_held >= MAXH) begin
          model_release();
          m_to = 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; req = '0; done = '0; busy = 1'b0; data = 32'h11223344;
    repeat (3) @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_checks++; if (gvld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", gvld); end
    n_checks++; if (gidx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", gidx); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", to); end
    n_checks++; if (arb_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", arb_data); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL idle_noreq got=%b exp=0000", grant); end
  endtask

  task automatic test_basic();
    req = 4'b1010;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL basic_grant1 got=%b exp=0010", grant); end
    n_checks++; if (gidx !== 4'd1 || gvld !== 1'b1) begin n_fail++; $display("FAIL basic_idx1 got=%0d/%b exp=1/1", gidx, gvld); end
    req = 4'b1000;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000 || to !== 1'b0) begin n_fail++; $display("FAIL basic_gap got=%b/%b exp=0000/0", grant, to); end
    @(negedge clk);
    n_checks++; if (grant !== 4'b1000 || gidx !== 4'd3) begin n_fail++; $display("FAIL basic_grant3 got=%b/%0d exp=1000/3", grant, gidx); end
    done = 4'b1000;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL basic_done_rel got=%b exp=0000", grant); end
    done = '0; req = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      @(negedge clk);
      n_checks++; if (grant !== exp_g || gidx !== 4'(k % 4)) begin n_fail++; $display("FAIL fair_grant%0d got=%b/%0d exp=%b/%0d", k, grant, gidx, exp_g, k % 4); end
      done = exp_g;
      @(negedge clk);
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL fair_gap%0d got=%b exp=0000", k, grant); end
      done = '0;
    end
    req = '0;
  endtask

  task automatic test_lock();
    req = 4'b0100;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0100 || gidx !== 4'd2) begin n_fail++; $display("FAIL lock_grant got=%b/%0d exp=0100/2", grant, gidx); end
    busy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++; if (grant !== 4'b0100 || to !== 1'b0) begin n_fail++; $display("FAIL lock_hold%0d got=%b/%b exp=0100/0", c, grant, to); end
      done = (c == 4) ? 4'b0100 : (c == 6) ? 4'b0001 : 4'b0000;
      if (c == 10) req = 4'b0000;
    end
    busy = 1'b0;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000 || to !== 1'b0) begin n_fail++; $display("FAIL lock_release got=%b/%b exp=0000/0", grant, to); end
    req = 4'b1111;
    @(negedge clk);
    n_checks++; if (grant !== 4'b1000 || gidx !== 4'd3) begin n_fail++; $display("FAIL lock_ptr got=%b/%0d exp=1000/3", grant, gidx); end
    done = 4'b1000; req = '0;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL lock_after got=%b exp=0000", grant); end
    done = '0;
  endtask

  task automatic test_timeout();
    req = 4'b0011;
    for (int c = 0; c < MAXH; c++) begin
      @(negedge clk);
      n_checks++; if (grant !== 4'b0001 || to !== 1'b0) begin n_fail++; $display("FAIL to_hold%0d got=%b/%b exp=0001/0", c, grant, to); end
    end
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000 || to !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%b/%b exp=0000/1", grant, to); end
    @(negedge clk);
    n_checks++; if (grant !== 4'b0010 || to !== 1'b0) begin n_fail++; $display("FAIL to_next got=%b/%b exp=0010/0", grant, to); end
    req = '0;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL to_after got=%b exp=0000", grant); end
  endtask

  task automatic test_mux();
    data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    #1;
    n_checks++; if (arb_data !== 8'h00) begin n_fail++; $display("FAIL mux_nogrant got=%h exp=00", arb_data); end
    req = 4'b0100;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0100 || arb_data !== 8'hCC) begin n_fail++; $display("FAIL mux_cc got=%b/%h exp=0100/cc", grant, arb_data); end
    data = 32'h55667788;
    #1;
    n_checks++; if (arb_data !== 8'h66) begin n_fail++; $display("FAIL mux_comb got=%h exp=66", arb_data); end
    done = 4'b0100;
    @(negedge clk);
    n_checks++; if (arb_data !== 8'h00 || grant !== 4'b0000) begin n_fail++; $display("FAIL mux_rel got=%h/%b exp=00/0000", arb_data, grant); end
    done = '0; req = '0;
  endtask

  task automatic test_reset_mid();
    req = 4'b1111;
    @(negedge clk);
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rst_pre got=%b exp=1000", grant); end
    busy = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (grant !== 4'b0000 || gvld !== 1'b0 || gidx !== 4'd0 || to !== 1'b0)
      begin n_fail++; $display("FAIL rst_async got=%b/%b/%0d/%b exp=0000/0/0/0", grant, gvld, gidx, to); end
    @(negedge clk);
    busy = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001 || to !== 1'b0) begin n_fail++; $display("FAIL rst_regrant got=%b/%b exp=0001/0", grant, to); end
    done = 4'b0001; req = '0;
    @(negedge clk);
    done = '0;
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_d = (m_owner >= 0) ? data[8*m_owner +: 8] : 8'h00;
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      n_checks++; if (gidx !== ((m_owner >= 0) ? 4'(m_owner) : 4'd0) || gvld !== (m_owner >= 0))
        begin n_fail++; $display("FAIL rnd_idx c=%0d got=%0d/%b exp=%0d", c, gidx, gvld, m_owner); end
      n_checks++; if (to !== m_to) begin n_fail++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, to, m_to); end
      n_checks++; if (arb_data !== exp_d) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, arb_data, exp_d); end
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 5) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      data = $urandom;
    end
    req = '0; done = '0; busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_lock();
    test_timeout();
    test_mux();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
